// File: rtl/mul_pkg.sv
// Shared definitions for the multiply sequencer: FSM state encoding,
// default operand width and the default multiplier latency expression.
package mul_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_CAPTURE
    } mul_state_t;

    // The external shift-add multiplier needs two cycles per operand bit plus setup/teardown.
    function automatic int mul_latency(input int width);
        return 2 * width + 2;
    endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Request/result bus between a consumer (master) and the multiply sequencer (slave).
interface mul_sequencer_if
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             Start;
    logic             Ready;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             Sgn;
    logic             ReadReq;
    logic             Stall;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, OpA, OpB, Sgn, ReadReq,
        input  Ready, Stall, Busy, Done, Hi, Lo
    );

    modport slave (
        input  Start, OpA, OpB, Sgn, ReadReq,
        output Ready, Stall, Busy, Done, Hi, Lo
    );
endinterface

// File: rtl/mul_fifo1.sv
// One-entry holding buffer for an operand set accepted while the multiplier is occupied.
module mul_fifo1
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    input  logic             din_sgn,
    output logic             valid,
    output logic [WIDTH-1:0] dout_a,
    output logic [WIDTH-1:0] dout_b,
    output logic             dout_sgn
);

    // push is only issued while empty, so push and pop never coincide
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid    <= 1'b0;
            dout_a   <= '0;
            dout_b   <= '0;
            dout_sgn <= 1'b0;
        end else if (push) begin
            valid    <= 1'b1;
            dout_a   <= din_a;
            dout_b   <= din_b;
            dout_sgn <= din_sgn;
        end else if (pop) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Sequences operands into an external fixed-latency multiplier and captures Hi/Lo.
// Signed operation is built only when MUL_SIGNED_EN is defined.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | no operation in flight; launch from pending entry or new Start
// ST_LAUNCH  | MulSy high for this single cycle, latency counter loaded
// ST_WAIT    | counting down multiplier latency
// ST_CAPTURE | product written to Hi/Lo, Done pulsed, chain to pending entry
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int MUL_LATENCY = mul_latency(WIDTH)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    mul_sequencer_if.slave       bus,
    output logic [WIDTH-1:0]     MulA,
    output logic [WIDTH-1:0]     MulB,
    output logic                 MulSy,
    input  logic [2*WIDTH-1:0]   MulProduct
);

    localparam int            CW     = $clog2(MUL_LATENCY) + 1;
    localparam logic [CW-1:0] LAT_M1 = CW'(MUL_LATENCY - 1);

    mul_state_t       state;
    logic [CW-1:0]    cnt;
    logic             neg;
    logic             busy;
    logic             accept;
    logic             push;
    logic             pop;
    logic             pend_valid;
    logic [WIDTH-1:0] pend_a;
    logic [WIDTH-1:0] pend_b;
    logic             pend_sgn;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             src_sgn;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             src_neg;

    assign busy        = (state != ST_IDLE);
    assign bus.Ready   = !pend_valid;
    assign bus.Busy    = busy;
    assign bus.Stall   = bus.ReadReq && (busy || pend_valid);

    assign accept = bus.Start && !pend_valid;
    assign push   = accept && busy;
    assign pop    = pend_valid && ((state == ST_IDLE) || (state == ST_CAPTURE));

    // The pending entry always launches before any new request.
    assign src_a   = pend_valid ? pend_a   : bus.OpA;
    assign src_b   = pend_valid ? pend_b   : bus.OpB;
    assign src_sgn = pend_valid ? pend_sgn : bus.Sgn;

`ifdef MUL_SIGNED_EN
    // Negating the most-negative value wraps back to itself, which is its correct unsigned magnitude.
    always_comb begin
        mag_a   = src_a;
        mag_b   = src_b;
        src_neg = 1'b0;
        if (src_sgn) begin
            mag_a   = src_a[WIDTH-1] ? -src_a : src_a;
            mag_b   = src_b[WIDTH-1] ? -src_b : src_b;
            src_neg = src_a[WIDTH-1] ^ src_b[WIDTH-1];
        end
    end
`else
    logic unused_sgn;
    assign unused_sgn = src_sgn;
    assign mag_a      = src_a;
    assign mag_b      = src_b;
    assign src_neg    = 1'b0;
`endif

    mul_fifo1 #(.WIDTH(WIDTH)) u_pending (
        .Clk      (Clk),
        .Reset    (Reset),
        .push     (push),
        .pop      (pop),
        .din_a    (bus.OpA),
        .din_b    (bus.OpB),
        .din_sgn  (bus.Sgn),
        .valid    (pend_valid),
        .dout_a   (pend_a),
        .dout_b   (pend_b),
        .dout_sgn (pend_sgn)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            neg      <= 1'b0;
            MulA     <= '0;
            MulB     <= '0;
            MulSy    <= 1'b0;
            bus.Hi   <= '0;
            bus.Lo   <= '0;
            bus.Done <= 1'b0;
        end else begin
            MulSy    <= 1'b0;
            bus.Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pend_valid || accept) begin
                        state <= ST_LAUNCH;
                        MulSy <= 1'b1;
                        MulA  <= mag_a;
                        MulB  <= mag_b;
                        neg   <= src_neg;
                    end
                end
                ST_LAUNCH: begin
                    cnt   <= LAT_M1;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    {bus.Hi, bus.Lo} <= neg ? -MulProduct : MulProduct;
                    bus.Done         <= 1'b1;
                    if (pend_valid) begin
                        state <= ST_LAUNCH;
                        MulSy <= 1'b1;
                        MulA  <= mag_a;
                        MulB  <= mag_b;
                        neg   <= src_neg;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
